// File: rtl/sd_ramdisk_pkg.sv
// sd_ramdisk shared types and constants.
// Sector geometry, fill byte and FSM state encoding.
package sd_ramdisk_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_SHIFT = 9;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [8:0] LAST_BYTE = 9'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DLY     = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_PUT  = 3'd3,
    S_WR_ADDR = 3'd4,
    S_WR_CAP  = 3'd5,
    S_WR_REQ  = 3'd6,
    S_DONE    = 3'd7
  } sdr_state_t;

endpackage

// File: rtl/sd_ramdisk.sv
// sd_ramdisk: sector-request responder backed by byte-wide memory.
// Optional write protect input via SD_RAMDISK_WPROT_EN.
module sd_ramdisk
  import sd_ramdisk_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int ACK_DLY = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       img_size,
  input  logic              img_mounted,
`ifdef SD_RAMDISK_WPROT_EN
  input  logic              img_wp,
`endif
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready
);

  localparam int LBA_W = ADDR_W - SECTOR_SHIFT;

  sdr_state_t       r_state;
  logic [3:0]       r_dly;
  logic [8:0]       r_cnt;
  logic [LBA_W-1:0] r_lba;
  logic             r_dir;
  logic             r_hit;
  logic             r_wp;
  logic [7:0]       r_data;
  logic             r_ack;
  logic [22:0]      r_sectors;

  logic w_req;
  logic w_hit;
  logic w_wp_in;
  logic w_store;
  logic w_last;
  logic w_unused;

`ifdef SD_RAMDISK_WPROT_EN
  assign w_wp_in = img_wp;
`else
  assign w_wp_in = 1'b0;
`endif

  assign w_req   = sd_rd | sd_wr;
  assign w_hit   = (sd_lba < {9'd0, r_sectors}) &&
                   (sd_lba[31:LBA_W] == '0);
  assign w_store = r_hit & ~r_wp;
  assign w_last  = (r_cnt == LAST_BYTE);

  assign w_unused = &{1'b0, img_size[8:0]};

  // Request accept, ack delay and per-byte transfer sequencing
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_dly     <= '0;
      r_cnt     <= '0;
      r_lba     <= '0;
      r_dir     <= 1'b0;
      r_hit     <= 1'b0;
      r_wp      <= 1'b0;
      r_data    <= '0;
      r_ack     <= 1'b0;
      r_sectors <= '0;
    end else begin
      if (img_mounted) r_sectors <= img_size[31:9];
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_lba   <= sd_lba[LBA_W-1:0];
            r_dir   <= sd_rd;
            r_hit   <= w_hit;
            r_wp    <= w_wp_in;
            r_cnt   <= '0;
            r_dly   <= '0;
            r_state <= S_DLY;
          end
        end
        S_DLY: begin
          if (r_dly == 4'(ACK_DLY - 1)) begin
            r_ack   <= 1'b1;
            r_state <= r_dir ? S_RD_REQ : S_WR_ADDR;
          end else begin
            r_dly <= r_dly + 4'd1;
          end
        end
        S_RD_REQ: begin
          if (!r_hit) begin
            r_data  <= FILL_BYTE;
            r_state <= S_RD_PUT;
          end else if (mem_ready) begin
            r_data  <= mem_din;
            r_state <= S_RD_PUT;
          end
        end
        S_RD_PUT: begin
          if (w_last) begin
            r_ack   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 9'd1;
            r_state <= S_RD_REQ;
          end
        end
        S_WR_ADDR: r_state <= S_WR_CAP;
        S_WR_CAP: begin
          r_data  <= sd_buff_din;
          r_state <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (!w_store || mem_ready) begin
            if (w_last) begin
              r_ack   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + 9'd1;
              r_state <= S_WR_ADDR;
            end
          end
        end
        S_DONE: begin
          if (!w_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sd_ack       = r_ack;
  assign sd_buff_addr = r_cnt;
  assign sd_buff_dout = r_data;
  assign sd_buff_wr   = (r_state == S_RD_PUT);
  assign mem_addr     = {r_lba, r_cnt};
  assign mem_rd       = (r_state == S_RD_REQ) & r_hit;
  assign mem_wr       = (r_state == S_WR_REQ) & w_store;
  assign mem_dout     = r_data;

endmodule

// File: doc/sd_ramdisk.md
Name: sd_ramdisk

Overview:
- Responder end of the core's sector-request interface (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`).
- Services 512-byte sector reads and writes from a byte-wide backing memory holding a disk image (e.g. DSK preloaded via ioctl into DDR/SDRAM/BRAM).
- Sits between the disk controller (initiator) and the memory arbiter; used for on-board RAM disks and as the bench model of the HPS side.

Parameters:
- `ADDR_W`, 20, backing-memory byte address width (image capacity 2^ADDR_W bytes).
- `ACK_DLY`, 2, idle cycles between request detection and `sd_ack` rise (1..15).

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `img_size`  in  32  image size in bytes; sampled on `img_mounted`.
- `img_mounted`  in  1  one-cycle pulse: new image present.
- `sd_lba`  in  32  requested sector number; sampled at request accept.
- `sd_rd`  in  1  read request level, held by initiator until `sd_ack` seen.
- `sd_wr`  in  1  write request level, same rule.
- `sd_ack`  out  1  high for whole transfer.
- `sd_buff_addr`  out  9  byte index within sector.
- `sd_buff_dout`  out  8  read data to initiator buffer.
- `sd_buff_wr`  out  1  strobe: `sd_buff_dout` valid for `sd_buff_addr`.
- `sd_buff_din`  in  8  initiator buffer data; valid 1 cycle after `sd_buff_addr` is presented.
- `mem_addr`  out  ADDR_W  backing-memory byte address.
- `mem_rd`  out  1  read request; held until `mem_ready`.
- `mem_wr`  out  1  write request; held until `mem_ready`.
- `mem_dout`  out  8  write data.
- `mem_din`  in  8  read data, valid with `mem_ready` during `mem_rd`.
- `mem_ready`  in  1  one-cycle completion pulse.

Behaviour:
- **Reset:** all outputs 0; `img_sectors` = 0; FSM in IDLE. Reset is asynchronous and aborts any transfer immediately. `mem_rd`/`mem_wr` drop without waiting for `mem_ready`.
- **Image size:** on `img_mounted`, `img_sectors` <= `img_size[31:9]`. A partial trailing sector is ignored. If `img_mounted` arrives mid-transfer, the new size applies from the next request.
- **States:** IDLE, DLY, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, DONE.
- **IDLE:** on `sd_rd` or `sd_wr`, latch `lba`, `dir` = `sd_rd` (read has priority when both are high), `hit` = (`lba` < `img_sectors`) AND (`lba` < 2^(ADDR_W-9)). Clear `cnt` (9 bits), go to DLY.
- **DLY:** count `ACK_DLY` cycles, then set `sd_ack` = 1 and go to RD_REQ if `dir`, else WR_ADDR.
- **Address:** `mem_addr` = {`lba`[ADDR_W-10:0], `cnt`}.
- **RD_REQ:**
  - If `hit`: assert `mem_rd` and wait for `mem_ready`, capturing `mem_din`.
  - If not `hit`: skip memory and use 0xFF.
  - Then go to RD_PUT.
- **RD_PUT:** one cycle with `sd_buff_wr` = 1, `sd_buff_addr` = `cnt`, `sd_buff_dout` = captured byte. If `cnt` == 511, go to DONE; else `cnt`++ and return to RD_REQ.
- **WR_ADDR:** drive `sd_buff_addr` = `cnt`, go to WR_CAP.
- **WR_CAP:** capture `sd_buff_din` into `mem_dout`, go to WR_REQ.
- **WR_REQ:**
  - If `hit`: assert `mem_wr` and wait for `mem_ready`.
  - If not `hit`: the byte is discarded with no memory cycle.
  - If `cnt` == 511, go to DONE; else `cnt`++ and go to WR_ADDR.
- **DONE:** `sd_ack` = 0. Wait until `sd_rd` = 0 and `sd_wr` = 0, then go to IDLE. This prevents a held request from retriggering.
- **Request drop:** request deassertion during DLY..WR_REQ is ignored; the sector always completes with exactly 512 strobes/stores.
- `sd_lba` changes after accept are ignored.
- **Latency:** first `sd_buff_wr` occurs at least `ACK_DLY` + 2 cycles after request (`mem_ready` in 1 cycle). Minimum throughput is one byte per 2 cycles for reads and per 3 cycles for writes, plus memory wait.

Optional Feature:
- Macro: `SD_RAMDISK_WPROT_EN`.
- **Defined:** adds input port `img_wp` (1 bit), sampled at request accept.
  - Write requests with `img_wp` = 1 still run the full ack/512-byte buffer read sequence.
  - `mem_wr` is never asserted, so the image is unchanged and the initiator sees a normal completion.
- **Undefined:** no port; writes always store when `hit`.

Decomposition:
- Package `sd_ramdisk_pkg`:
  - State enum `sdr_state_t`.
  - `SECTOR_BYTES` = 512, `SECTOR_SHIFT` = 9.
  - `FILL_BYTE` = 8'hFF.
- No sub-module needed; optionally `sdr_delay` counter inline. Single flat FSM plus datapath registers.

Test Plan:
- **Read hit:** preload mem[0x400..0x5FF] = addr[7:0]; `img_size` = 0x10000; `sd_rd` with `sd_lba` = 2.
  - `sd_ack` rises after 2 cycles.
  - 512 `sd_buff_wr` strobes with `sd_buff_addr` 0..511, `sd_buff_dout` = 0x00..0xFF repeating.
  - `sd_ack` falls; FSM re-arms only after `sd_rd` drops.
- **Write hit:** initiator buffer holds 0xA5^idx; `sd_wr`, `lba` = 1.
  - mem[0x200+i] = 0xA5^i for all 512 bytes.
  - Exactly 512 `mem_wr` pulses; no `sd_buff_wr`.
- **Out of range:** `img_size` = 0x800 (4 sectors); `sd_rd` `lba` = 4 → 512 bytes of 0xFF with no `mem_rd`. `sd_wr` `lba` = 7 → no `mem_wr`, `sd_ack` still completes.
- **Collision and hold:** `sd_rd` and `sd_wr` asserted together → read performed. Request held high through DONE → no second transfer until it is low for at least 1 cycle.
- **Reset mid-sector:** `reset_n` low at byte 100 of a read with memory stalled (`mem_ready` withheld).
  - `sd_ack`, `mem_rd` and `sd_buff_wr` are 0 asynchronously.
  - After release, a new read of `lba` 0 returns all 512 bytes correctly.
- **WPROT (macro defined):** `img_wp` = 1, `sd_wr` `lba` = 0 → 512 `sd_buff_addr` steps, zero `mem_wr`, memory unchanged. `img_wp` = 0 → writes land.
